hdmi_line_feeder: RTL and testbench

Scanout stage directly upstream of the HDMI encoder. It streams 8-bpp palette-indexed framebuffer lines from memory into a ping-pong line buffer, then expands each index through a 256-entry RGB888 palette onto the encoder's `red`/`green`/`blue` inputs, paced by `fetch_next`, `next_line` and `next_field`. It runs entirely on the encoder's pixel clock and requests memory words through a valid/ready port.

---
 rtl/hdmi_line_feeder.sv | 254 +++++++++++++++++++++++++
 tb/tb_hdmi_line_feeder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_line_feeder.sv
// hdmi_line_feeder
//   Scanout stage feeding the HDMI encoder. Streams 8-bpp palette-indexed
//   framebuffer lines from memory into a ping-pong line buffer and expands
//   each index through a 256-entry RGB888 palette, paced by the encoder's
//   fetch_next / next_line / next_field strobes. Single clock domain.
//
// Ports
//   clk_pixel, rst_n        pixel clock, async active-low reset
//   enable                  scanout enable (gates new requests and RGB)
//   fb_base                 framebuffer byte address of line 0 (latched on next_field)
//   mem_valid/addr/ready    word read request port; mem_rdata valid with mem_ready
//   mem_rdata               four pixels, pixel 4n+i in bits [8i+7:8i]
//   pal_we/addr/wdata       palette write port, {R,G,B}
//   fetch_next              encoder consumed the current pixel
//   next_line, next_field   line / field pacing pulses
//   red, green, blue        current pixel
//   underflow               sticky: a pixel was consumed before its word arrived
module hdmi_line_feeder #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 24
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              pal_we,
    input  logic [7:0]        pal_addr,
    input  logic [23:0]       pal_wdata,
    input  logic              fetch_next,
    input  logic              next_line,
    input  logic              next_field,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              underflow
);

    localparam int unsigned WORDS = H_ACTIVE / 4;
    localparam int unsigned WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam int unsigned PW    = $clog2(H_ACTIVE + 2);
    localparam int unsigned LW    = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    // Fetch side
    state_t            r_state;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_fb;
    logic [CW-1:0]     r_cnt [2];
    logic [1:0]        r_free;
    logic              r_fill_buf;
    logic [LW-1:0]     r_fetch_line;

    // Storage: buffers are laid out at a power-of-two stride, {buf, word}
    logic [31:0]       r_buf [2**(WAW+1)];
    logic [23:0]       r_pal [256];

    // Pixel side
    logic              r_rd_buf;
    logic [PW-1:0]     r_pix;
    logic              r_underflow;
    logic              r_active;
    logic [7:0]        r_cur_idx;
    logic [7:0]        r_nxt_idx;
    logic              r_cur_ok;
    logic              r_nxt_ok;
    logic [23:0]       r_rgb;

    logic              w_xfer;
    logic              w_fill_last;
    logic              w_can_start;
    logic              w_sel;
    logic [ADDR_W-1:0] w_line_addr;
    logic [PW-1:0]     w_p_new;
    logic [PW-1:0]     w_p_nxt;
    logic [31:0]       w_cur_word;
    logic [31:0]       w_nxt_word;
    logic              w_cur_ok;
    logic              w_nxt_ok;
    logic              w_miss;
    logic              w_sel_ok;
    logic [7:0]        w_sel_idx;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    assign w_xfer      = (r_state == S_FILL) && r_mem_valid && mem_ready && !next_field;
    assign w_fill_last = (r_cnt[r_fill_buf] == CW'(WORDS - 1));
    assign w_can_start = (|r_free) && (r_fetch_line < LW'(V_ACTIVE));
    assign w_sel       = r_free[0] ? 1'b0 : 1'b1;
    assign w_line_addr = r_fb + ADDR_W'(r_fetch_line) * ADDR_W'(H_ACTIVE);

    // ------------------------------------------------------------------
    // Fetch FSM: fills free buffers in line order, one word per handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_fb         <= '0;
            r_cnt[0]     <= '0;
            r_cnt[1]     <= '0;
            r_free       <= '0;
            r_fill_buf   <= 1'b0;
            r_fetch_line <= '0;
        end else if (next_field) begin
            // Abort any fill; restart with line 0 into B0 (w_sel prefers B0)
            r_fb         <= fb_base;
            r_state      <= S_DONE;
            r_mem_valid  <= 1'b0;
            r_cnt[0]     <= '0;
            r_cnt[1]     <= '0;
            r_free       <= 2'b11;
            r_fetch_line <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_can_start) begin
                        r_state        <= S_FILL;
                        r_fill_buf     <= w_sel;
                        r_free[w_sel]  <= 1'b0;
                        r_cnt[w_sel]   <= '0;
                        r_mem_addr     <= w_line_addr;
                        r_mem_valid    <= enable;
                        r_fetch_line   <= r_fetch_line + LW'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (r_mem_valid) begin
                        if (mem_ready) begin
                            r_cnt[r_fill_buf] <= r_cnt[r_fill_buf] + CW'(1);
                            r_mem_addr        <= r_mem_addr + ADDR_W'(4);
                            if (w_fill_last) begin
                                r_mem_valid <= 1'b0;
                                r_state     <= S_DONE;
                            end else begin
                                r_mem_valid <= enable;
                            end
                        end
                    end else begin
                        r_mem_valid <= enable;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Old read buffer is released; a fill running into the new read
            // buffer is left to complete before this one is picked up.
            if (next_line) begin
                r_free[r_rd_buf] <= 1'b1;
                r_cnt[r_rd_buf]  <= '0;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (w_xfer) begin
            r_buf[{r_fill_buf, WAW'(r_cnt[r_fill_buf])}] <= mem_rdata;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Pixel path. Indices for both the current pixel and the one after it
    // are staged each cycle, so a fetch_next can switch the palette lookup
    // to the following pixel and still show it on the very next cycle.
    // ------------------------------------------------------------------
    assign w_p_new = (fetch_next && (r_pix < PW'(H_ACTIVE))) ? r_pix + PW'(1) : r_pix;
    assign w_p_nxt = w_p_new + PW'(1);

    assign w_cur_word = r_buf[{r_rd_buf, WAW'(w_p_new >> 2)}];
    assign w_nxt_word = r_buf[{r_rd_buf, WAW'(w_p_nxt >> 2)}];
    assign w_cur_ok   = (w_p_new < PW'(H_ACTIVE)) && (CW'(w_p_new >> 2) < r_cnt[r_rd_buf]);
    assign w_nxt_ok   = (w_p_nxt < PW'(H_ACTIVE)) && (CW'(w_p_nxt >> 2) < r_cnt[r_rd_buf]);

    // Consuming an in-range pixel whose word is not yet in the buffer
    assign w_miss = fetch_next && r_active && enable && (r_pix < PW'(H_ACTIVE)) &&
                    !(CW'(r_pix >> 2) < r_cnt[r_rd_buf]);

    assign w_sel_ok  = fetch_next ? r_nxt_ok  : r_cur_ok;
    assign w_sel_idx = fetch_next ? r_nxt_idx : r_cur_idx;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_buf    <= 1'b0;
            r_pix       <= '0;
            r_underflow <= 1'b0;
            r_active    <= 1'b0;
            r_cur_idx   <= '0;
            r_nxt_idx   <= '0;
            r_cur_ok    <= 1'b0;
            r_nxt_ok    <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_rgb <= (enable && w_sel_ok) ? r_pal[w_sel_idx] : '0;
            if (next_field) begin
                r_rd_buf    <= 1'b0;
                r_pix       <= '0;
                r_underflow <= 1'b0;
                r_active    <= 1'b1;
                r_cur_ok    <= 1'b0;
                r_nxt_ok    <= 1'b0;
            end else if (next_line) begin
                r_rd_buf <= ~r_rd_buf;
                r_pix    <= '0;
                r_cur_ok <= 1'b0;
                r_nxt_ok <= 1'b0;
            end else begin
                r_pix     <= w_p_new;
                r_cur_idx <= byte_sel(w_cur_word, w_p_new[1:0]);
                r_nxt_idx <= byte_sel(w_nxt_word, w_p_nxt[1:0]);
                r_cur_ok  <= w_cur_ok;
                r_nxt_ok  <= w_nxt_ok;
                if (w_miss) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign red       = r_rgb[23:16];
    assign green     = r_rgb[15:8];
    assign blue      = r_rgb[7:0];
    assign underflow = r_underflow;

endmodule

// File: tb/tb_hdmi_line_feeder.sv
// tb_hdmi_line_feeder
//   Directed bench for hdmi_line_feeder with a 640-pixel, 4-line field.
//   Memory returns byte a[7:0] at address a; palette entry k = {k, ~k, k^5A}.
module tb_hdmi_line_feeder;

    localparam int H = 640;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [23:0] fb_base;
    logic        mem_valid;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        fetch_next;
    logic        next_line;
    logic        next_field;
    logic [7:0]  red, green, blue;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    hdmi_line_feeder #(
        .H_ACTIVE(640),
        .V_ACTIVE(4),
        .ADDR_W  (24)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .enable    (enable),
        .fb_base   (fb_base),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .fetch_next(fetch_next),
        .next_line (next_line),
        .next_field(next_field),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .underflow (underflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Memory: byte at address a is a[7:0]
    logic [7:0] m_b0;
    always_comb begin
        m_b0      = mem_addr[7:0];
        mem_rdata = {m_b0 + 8'd3, m_b0 + 8'd2, m_b0 + 8'd1, m_b0};
    end

    function automatic logic [23:0] pal_of(input logic [7:0] k);
        return {k, ~k, k ^ 8'h5A};
    endfunction

    function automatic logic [23:0] exp_px(input int base, input int line, input int p, input int cnt);
        int a;
        if (p >= H || (p / 4) >= cnt) return 24'h0;
        a = base + line * H + p;
        return pal_of(a[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pulse_nl();
        next_line = 1'b1;
        tick();
        next_line = 1'b0;
    endtask

    task automatic pulse_nf();
        next_field = 1'b1;
        tick();
        next_field = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (!mem_valid && i < 64) begin
            tick();
            i++;
        end
        chk(tag, 32'(mem_valid), 32'd1);
    endtask

    // Check pixels 0..n of a line while issuing n back-to-back fetch_next
    task automatic walk(input int base, input int line, input int n, input int cnt);
        for (int p = 0; p <= n; p++) begin
            chk($sformatf("L%0d_p%0d", line, p), 32'({red, green, blue}), 32'(exp_px(base, line, p, cnt)));
            if (line == 1 && p == 3 && base == 32'h1000)
                chk("l1p3", 32'({red, green, blue}), 32'h837CD9);
            if (p < n) begin
                fetch_next = 1'b1;
                tick();
            end
        end
        fetch_next = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        fb_base    = 24'h0;
        mem_ready  = 1'b1;
        pal_we     = 1'b0;
        pal_addr   = 8'h0;
        pal_wdata  = 24'h0;
        fetch_next = 1'b0;
        next_line  = 1'b0;
        next_field = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_rgb",   32'({red, green, blue}), 32'd0);
        chk("rst_uf",    32'(underflow), 32'd0);

        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_valid", 32'(mem_valid), 32'd0);
        chk("idle_rgb",   32'({red, green, blue}), 32'd0);

        for (int k = 0; k < 256; k++) begin
            pal_we    = 1'b1;
            pal_addr  = 8'(k);
            pal_wdata = pal_of(8'(k));
            tick();
        end
        pal_we = 1'b0;

        // Full field at 0x1000, memory always ready
        fb_base = 24'h1000;
        pulse_nf();
        wait_valid("f1_req");
        chk("f1_addr", 32'(mem_addr), 32'h1000);
        repeat (400) tick();

        // Palette write: old value on the first cycle, new on the second
        chk("pal_pre", 32'({red, green, blue}), 32'h00FF5A);
        pal_we = 1'b1; pal_addr = 8'h00; pal_wdata = 24'hABCDEF;
        tick();
        pal_we = 1'b0;
        chk("pal_old", 32'({red, green, blue}), 32'h00FF5A);
        tick();
        chk("pal_new", 32'({red, green, blue}), 32'hABCDEF);
        pal_we = 1'b1; pal_wdata = pal_of(8'h00);
        tick();
        pal_we = 1'b0;
        tick();
        chk("pal_rest", 32'({red, green, blue}), 32'h00FF5A);

        // Enable low forces black
        enable = 1'b0;
        repeat (2) tick();
        chk("en_lo", 32'({red, green, blue}), 32'd0);
        enable = 1'b1;
        repeat (2) tick();
        chk("en_hi", 32'({red, green, blue}), 32'h00FF5A);

        walk(32'h1000, 0, 640, 160);
        chk("uf_l0", 32'(underflow), 32'd0);
        pulse_nl(); repeat (2) tick();
        walk(32'h1000, 1, 640, 160);
        chk("uf_l1", 32'(underflow), 32'd0);
        pulse_nl(); repeat (2) tick();
        walk(32'h1000, 2, 640, 160);
        pulse_nl(); repeat (3) tick();
        chk("no_line4_req", 32'(mem_valid), 32'd0);
        // Excess fetch_next past the end of the line
        walk(32'h1000, 3, 700, 160);
        chk("uf_excess", 32'(underflow), 32'd0);

        // Starved fill of line 2: only two words arrive
        pulse_nf();
        wait_valid("f2_req");
        repeat (400) tick();
        mem_ready = 1'b0;
        pulse_nl();
        wait_valid("l2_req");
        chk("l2_addr", 32'(mem_addr), 32'h1500);
        mem_ready = 1'b1;
        repeat (2) tick();
        mem_ready = 1'b0;
        chk("l2_addr2", 32'(mem_addr), 32'h1508);
        pulse_nl(); repeat (2) tick();
        walk(32'h1000, 2, 12, 2);
        chk("uf_set", 32'(underflow), 32'd1);
        repeat (300) tick();
        chk("stall_valid", 32'(mem_valid), 32'd1);
        chk("stall_addr",  32'(mem_addr),  32'h1508);

        // next_field mid-fill aborts and restarts at the new base
        fb_base = 24'h2000;
        pulse_nf();
        chk("abort_valid", 32'(mem_valid), 32'd0);
        chk("uf_clr",      32'(underflow), 32'd0);
        mem_ready = 1'b1;
        wait_valid("f3_req");
        chk("f3_addr", 32'(mem_addr), 32'h2000);

        // next_line together with next_field: field restart wins
        fb_base    = 24'h1000;
        next_line  = 1'b1;
        next_field = 1'b1;
        tick();
        next_line  = 1'b0;
        next_field = 1'b0;
        repeat (200) tick();
        chk("b1_filling", 32'(mem_valid), 32'd1);
        walk(32'h1000, 0, 8, 160);

        // Reset during a fill
        rst_n = 1'b0;
        #1;
        chk("rstf_valid", 32'(mem_valid), 32'd0);
        chk("rstf_rgb",   32'({red, green, blue}), 32'd0);
        chk("rstf_addr",  32'(mem_addr),  32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("rstf_noreq", 32'(mem_valid), 32'd0);
        fb_base = 24'h3000;
        pulse_nf();
        wait_valid("f4_req");
        chk("f4_addr", 32'(mem_addr), 32'h3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
